// File: rtl/datapath_regfile_alu.sv
// datapath_regfile_alu
// Execution half of the controller/datapath pair. It holds a small register
// file, two operand muxes, an ALU and a one-bit shifter. It also has a
// registered result/flag stage that the control FSM branches on. An external
// load port seeds registers before a control program starts.
module datapath_regfile_alu #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [7:0]       selection_multa,
  input  logic [7:0]       selection_multb,
  input  logic [7:0]       selection_alu,
  input  logic [7:0]       selection_sr,
  input  logic [NREGS-1:0] writer,
  input  logic             clr_in,
  input  logic             load_en,
  input  logic [7:0]       load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [7:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] res_q,
  output logic             fov,
  output logic             fcarry,
  output logic             fneg,
  output logic             fzero
);

  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             is_arith;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             alu_ov;
  logic [WIDTH-1:0] sh_out;
  logic             sh_on;
  logic             sh_carry;

  // Operand and debug-read muxes; the full 8-bit index is compared, so any
  // out-of-range select yields 0 instead of aliasing onto a real register.
  always_comb begin
    op_a    = '0;
    op_b    = '0;
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (32'(selection_multa) == 32'(i)) op_a = regs[i];
      if (32'(selection_multb) == 32'(i)) op_b = regs[i];
      if (32'(rd_addr) == 32'(i))         rd_data = regs[i];
    end
  end

  // ALU: a single adder handles add and subtract (A + ~B + 1), so for
  // subtraction the carry-out means "no borrow".
  always_comb begin
    is_arith = (selection_alu == 8'd1) || (selection_alu == 8'd2);
    b_eff    = (selection_alu == 8'd2) ? ~op_b : op_b;
    cin      = (selection_alu == 8'd2);
    sum      = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    case (selection_alu)
      8'd0:    alu_out = op_a;
      8'd1:    alu_out = sum[WIDTH-1:0];
      8'd2:    alu_out = sum[WIDTH-1:0];
      8'd3:    alu_out = op_a & op_b;
      8'd4:    alu_out = op_a | op_b;
      8'd5:    alu_out = op_a ^ op_b;
      8'd6:    alu_out = ~op_a;
      8'd7:    alu_out = op_b;
      default: alu_out = '0;
    endcase
    alu_carry = is_arith & sum[WIDTH];
    alu_ov    = is_arith & (op_a[WIDTH-1] == b_eff[WIDTH-1]) &
                (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  // Shifter on the ALU output; when active, its shifted-out bit replaces the adder carry.
  always_comb begin
    sh_on    = 1'b1;
    sh_out   = alu_out;
    sh_carry = 1'b0;
    case (selection_sr)
      8'd1: begin
        sh_out   = {alu_out[WIDTH-2:0], 1'b0};
        sh_carry = alu_out[WIDTH-1];
      end
      8'd2: begin
        sh_out   = {1'b0, alu_out[WIDTH-1:1]};
        sh_carry = alu_out[0];
      end
      8'd3: begin
        sh_out   = {alu_out[WIDTH-1], alu_out[WIDTH-1:1]};
        sh_carry = alu_out[0];
      end
      default: sh_on = 1'b0;
    endcase
  end

  // Result/flag stage: updates every cycle, with clr_in forcing it to zero.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      res_q  <= '0;
      fov    <= 1'b0;
      fcarry <= 1'b0;
      fneg   <= 1'b0;
      fzero  <= 1'b0;
    end else if (clr_in) begin
      res_q  <= '0;
      fov    <= 1'b0;
      fcarry <= 1'b0;
      fneg   <= 1'b0;
      fzero  <= 1'b0;
    end else begin
      res_q  <= sh_out;
      fov    <= alu_ov & ~sh_on;
      fcarry <= sh_on ? sh_carry : alu_carry;
      fneg   <= sh_out[WIDTH-1];
      fzero  <= (sh_out == '0);
    end
  end

  // Register file writes. The external load beats a write-back to the same
  // register, and clr_in suppresses write-back but not loads.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (load_en && (32'(load_addr) == 32'(i))) regs[i] <= load_data;
        else if (!clr_in && writer[i])             regs[i] <= res_q;
      end
    end
  end

endmodule
